// File: rtl/axi_lite_pkg.sv
// Shared encodings and default widths for the AXI4-Lite read path.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

endpackage

// File: rtl/axi_lite_read_arbiter_if.sv
// Upstream requester bundle plus downstream slave channel of the read arbiter.
interface axi_lite_read_arbiter_if #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = axi_lite_pkg::ADDR_W,
  parameter int DATA_W = axi_lite_pkg::DATA_W
);

  logic [NUM_M*ADDR_W-1:0] S_ARADDR;
  logic [NUM_M-1:0]        S_ARVALID;
  logic [NUM_M-1:0]        S_ARREADY;
  logic [DATA_W-1:0]       S_RDATA;
  logic [1:0]              S_RRESP;
  logic [NUM_M-1:0]        S_RVALID;
  logic [NUM_M-1:0]        S_RREADY;

  logic [ADDR_W-1:0]       M_ARADDR;
  logic                    M_ARVALID;
  logic                    M_ARREADY;
  logic [DATA_W-1:0]       M_RDATA;
  logic [1:0]              M_RRESP;
  logic                    M_RVALID;
  logic                    M_RREADY;

  // The arbiter sits on this side: slave to the requesters, master downstream.
  modport slave (
    input  S_ARADDR, S_ARVALID, S_RREADY,
    input  M_ARREADY, M_RDATA, M_RRESP, M_RVALID,
    output S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    output M_ARADDR, M_ARVALID, M_RREADY
  );

  modport master (
    output S_ARADDR, S_ARVALID, S_RREADY,
    output M_ARREADY, M_RDATA, M_RRESP, M_RVALID,
    input  S_ARREADY, S_RDATA, S_RRESP, S_RVALID,
    input  M_ARADDR, M_ARVALID, M_RREADY
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_M = 2,
  parameter int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // NOTE: every output and temporary gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    // Walk offsets from farthest to nearest so the nearest request overrides.
    for (int off = NUM_M - 1; off >= 0; off--) begin
      sum = {1'b0, rr_ptr} + (IDX_W + 1)'(off);
      if (sum >= (IDX_W + 1)'(NUM_M)) sum = sum - (IDX_W + 1)'(NUM_M);
      idx = sum[IDX_W-1:0];
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// Shares one AXI4-Lite read slave among NUM_M requesters with round-robin
// arbitration and a single outstanding transaction.
module axi_lite_read_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = axi_lite_pkg::ADDR_W,
  parameter int DATA_W = axi_lite_pkg::DATA_W,
  parameter int GNT_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic                   ACLK,
  input  logic                   ARSTn,
  axi_lite_read_arbiter_if.slave bus,
  output logic                   BUSY,
  output logic [GNT_W-1:0]       GRANT
);

  import axi_lite_pkg::*;

  state_e            state;
  logic [NUM_M-1:0]  ar_ready;
  logic              m_arvalid;
  logic [ADDR_W-1:0] m_araddr;
  logic [GNT_W-1:0]  rr_ptr;

  logic              grant_valid;
  logic [GNT_W-1:0]  grant_idx;
  logic [ADDR_W-1:0] addr_sel;
  logic [NUM_M-1:0]  rvalid;
  logic              m_rready;
  logic              r_done;

  rr_arbiter #(.NUM_M(NUM_M), .IDX_W(GNT_W)) u_rr (
    .req         (bus.S_ARVALID),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_M; i++)
      if (grant_idx == GNT_W'(i)) addr_sel = bus.S_ARADDR[i*ADDR_W +: ADDR_W];
  end

  assign r_done = (state == DATA) && bus.M_RVALID && bus.S_RREADY[GRANT];

  // NOTE: asynchronous reset lives in the sensitivity list, and all state uses
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      state     <= IDLE;
      ar_ready  <= '0;
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      GRANT     <= '0;
      rr_ptr    <= '0;
    end else begin
      ar_ready <= '0;
      case (state)
        IDLE: if (grant_valid) begin
          GRANT     <= grant_idx;
          m_araddr  <= addr_sel;
          m_arvalid <= 1'b1;
          ar_ready  <= NUM_M'(1) << grant_idx;
          state     <= ADDR;
        end
        ADDR: if (bus.M_ARREADY) begin
          m_arvalid <= 1'b0;
          state     <= DATA;
        end
        DATA: if (r_done) begin
          rr_ptr <= (GRANT == GNT_W'(NUM_M - 1)) ? '0 : GRANT + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response path is only opened to the granted requester while in DATA.
  always_comb begin
    rvalid   = '0;
    m_rready = 1'b0;
    if (state == DATA) begin
      rvalid[GRANT] = bus.M_RVALID;
      m_rready      = bus.S_RREADY[GRANT];
    end
  end

  assign bus.S_ARREADY = ar_ready;
  assign bus.S_RVALID  = rvalid;
  assign bus.S_RDATA   = DATA_W'(bus.M_RDATA);
  assign bus.S_RRESP   = bus.M_RRESP;
  assign bus.M_ARADDR  = m_araddr;
  assign bus.M_ARVALID = m_arvalid;
  assign bus.M_RREADY  = m_rready;
  assign BUSY          = (state != IDLE);

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Directed bench for axi_lite_read_arbiter with a small register-read slave model
// (0x10 -> 25, 0x20 -> 50, anything else -> 0, always OKAY).
module tb_axi_lite_read_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = $clog2(NM);

  logic          ACLK = 1'b0;
  logic          ARSTn;
  logic          BUSY;
  logic [GW-1:0] GRANT;

  int n_cmp = 0;
  int n_bad = 0;

  axi_lite_read_arbiter_if #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_read_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK  (ACLK),
    .ARSTn (ARSTn),
    .bus   (bus),
    .BUSY  (BUSY),
    .GRANT (GRANT)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [31:0] slave_mem(input logic [31:0] a);
    case (a)
      32'h10:  return 32'd25;
      32'h20:  return 32'd50;
      default: return 32'd0;
    endcase
  endfunction

  // Downstream slave: ARREADY one cycle after ARVALID, RVALID the cycle after.
  always @(posedge ACLK or negedge ARSTn) begin
    if (!ARSTn) begin
      bus.M_ARREADY <= 1'b0;
      bus.M_RVALID  <= 1'b0;
      bus.M_RDATA   <= '0;
      bus.M_RRESP   <= '0;
    end else begin
      if (bus.M_ARVALID && bus.M_ARREADY) begin
        bus.M_ARREADY <= 1'b0;
        bus.M_RVALID  <= 1'b1;
        bus.M_RDATA   <= slave_mem(bus.M_ARADDR);
        bus.M_RRESP   <= axi_lite_pkg::RESP_OKAY;
      end else if (bus.M_ARVALID && !bus.M_RVALID) begin
        bus.M_ARREADY <= 1'b1;
      end
      if (bus.M_RVALID && bus.M_RREADY) bus.M_RVALID <= 1'b0;
    end
  end

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic drive_req(input int m, input logic [31:0] a);
    @(negedge ACLK);
    bus.S_ARADDR[m*AW +: AW] = a;
    bus.S_ARVALID[m]         = 1'b1;
  endtask

  task automatic drop_req(input int m);
    @(negedge ACLK);
    bus.S_ARVALID[m] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge ACLK);
    ARSTn         = 1'b0;
    bus.S_ARVALID = '0;
    bus.S_ARADDR  = '0;
    bus.S_RREADY  = '0;
    @(negedge ACLK);
    ARSTn = 1'b1;
  endtask

  task automatic wait_rvalid(input int m, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.S_RVALID[m]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.S_ARVALID = 2'b11;
    bus.S_ARADDR  = {32'h20, 32'h10};
    bus.S_RREADY  = 2'b11;
    step();
    step();
    n_cmp++; if (bus.S_ARREADY !== 2'b00) begin n_bad++; $display("FAIL reset_arready: got %b want 00", bus.S_ARREADY); end
    n_cmp++; if (bus.M_ARVALID !== 1'b0) begin n_bad++; $display("FAIL reset_m_arvalid: got %b want 0", bus.M_ARVALID); end
    n_cmp++; if (bus.M_ARADDR !== 32'h0) begin n_bad++; $display("FAIL reset_m_araddr: got %h want 0", bus.M_ARADDR); end
    n_cmp++; if (GRANT !== 1'b0) begin n_bad++; $display("FAIL reset_grant: got %0d want 0", GRANT); end
    n_cmp++; if (bus.S_RVALID !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", bus.S_RVALID); end
    n_cmp++; if (bus.M_RREADY !== 1'b0) begin n_bad++; $display("FAIL reset_m_rready: got %b want 0", bus.M_RREADY); end
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_single();
    bit ok;
    int pulses;
    apply_reset();
    bus.S_RREADY = 2'b11;
    drive_req(0, 32'h10);
    step();
    n_cmp++; if (bus.S_ARREADY !== 2'b01) begin n_bad++; $display("FAIL single_arready: got %b want 01", bus.S_ARREADY); end
    n_cmp++; if (GRANT !== 1'b0) begin n_bad++; $display("FAIL single_grant: got %0d want 0", GRANT); end
    n_cmp++; if (bus.M_ARVALID !== 1'b1) begin n_bad++; $display("FAIL single_m_arvalid: got %b want 1", bus.M_ARVALID); end
    n_cmp++; if (bus.M_ARADDR !== 32'h10) begin n_bad++; $display("FAIL single_m_araddr: got %h want 10", bus.M_ARADDR); end
    n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", BUSY); end
    // Address changes after grant must not leak downstream.
    @(negedge ACLK);
    bus.S_ARVALID[0]   = 1'b0;
    bus.S_ARADDR[31:0] = 32'h20;
    pulses = 0;
    ok     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.S_ARREADY != 2'b00) pulses++;
      if (bus.S_RVALID[0]) begin ok = 1'b1; break; end
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL single_rvalid_timeout: got %b want 1", ok); end
    n_cmp++; if (bus.S_RDATA !== 32'd25) begin n_bad++; $display("FAIL single_rdata: got %0d want 25", bus.S_RDATA); end
    n_cmp++; if (bus.S_RRESP !== 2'b00) begin n_bad++; $display("FAIL single_rresp: got %b want 00", bus.S_RRESP); end
    n_cmp++; if (bus.S_RVALID !== 2'b01) begin n_bad++; $display("FAIL single_rvalid_vec: got %b want 01", bus.S_RVALID); end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL single_extra_arready: got %0d want 0", pulses); end
    step();
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL single_idle: got %b want 0", BUSY); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    apply_reset();
    bus.S_RREADY = 2'b11;
    @(negedge ACLK);
    bus.S_ARADDR  = {32'h20, 32'h10};
    bus.S_ARVALID = 2'b11;
    step();
    n_cmp++; if (bus.S_ARREADY !== 2'b01) begin n_bad++; $display("FAIL sim_first_arready: got %b want 01", bus.S_ARREADY); end
    drop_req(0);
    wait_rvalid(0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sim_first_timeout: got %b want 1", ok); end
    n_cmp++; if (bus.S_RDATA !== 32'd25) begin n_bad++; $display("FAIL sim_first_rdata: got %0d want 25", bus.S_RDATA); end
    n_cmp++; if (bus.S_RVALID !== 2'b01) begin n_bad++; $display("FAIL sim_first_rvalid: got %b want 01", bus.S_RVALID); end
    step();
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL sim_gap_busy: got %b want 0", BUSY); end
    step();
    n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL sim_second_busy: got %b want 1", BUSY); end
    n_cmp++; if (bus.S_ARREADY !== 2'b10) begin n_bad++; $display("FAIL sim_second_arready: got %b want 10", bus.S_ARREADY); end
    n_cmp++; if (GRANT !== 1'b1) begin n_bad++; $display("FAIL sim_second_grant: got %0d want 1", GRANT); end
    n_cmp++; if (bus.M_ARADDR !== 32'h20) begin n_bad++; $display("FAIL sim_second_araddr: got %h want 20", bus.M_ARADDR); end
    drop_req(1);
    wait_rvalid(1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL sim_second_timeout: got %b want 1", ok); end
    n_cmp++; if (bus.S_RDATA !== 32'd50) begin n_bad++; $display("FAIL sim_second_rdata: got %0d want 50", bus.S_RDATA); end
    n_cmp++; if (bus.S_RVALID !== 2'b10) begin n_bad++; $display("FAIL sim_second_rvalid: got %b want 10", bus.S_RVALID); end
  endtask

  task automatic test_fairness();
    int exp_g[6] = '{0, 1, 0, 1, 0, 1};
    int got_g[6];
    int ng;
    int nr;
    logic [1:0]  exp_rv;
    logic [31:0] exp_rd;
    apply_reset();
    bus.S_RREADY = 2'b11;
    @(negedge ACLK);
    bus.S_ARADDR  = {32'h20, 32'h10};
    bus.S_ARVALID = 2'b11;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 80 && nr < 6; c++) begin
      step();
      if (bus.S_ARREADY != 2'b00 && ng < 6) begin
        got_g[ng] = int'(GRANT);
        ng++;
        if (ng == 6) begin
          @(negedge ACLK);
          bus.S_ARVALID = 2'b00;
        end
      end
      if (bus.S_RVALID != 2'b00) begin
        exp_rv = (exp_g[nr] == 0) ? 2'b01 : 2'b10;
        exp_rd = (exp_g[nr] == 0) ? 32'd25 : 32'd50;
        n_cmp++; if (bus.S_RVALID !== exp_rv) begin n_bad++; $display("FAIL fair_rvalid[%0d]: got %b want %b", nr, bus.S_RVALID, exp_rv); end
        n_cmp++; if (bus.S_RDATA !== exp_rd) begin n_bad++; $display("FAIL fair_rdata[%0d]: got %0d want %0d", nr, bus.S_RDATA, exp_rd); end
        nr++;
      end
    end
    n_cmp++; if (nr !== 6) begin n_bad++; $display("FAIL fair_count: got %0d want 6", nr); end
    for (int i = 0; i < ng; i++) begin
      n_cmp++; if (got_g[i] !== exp_g[i]) begin n_bad++; $display("FAIL fair_grant[%0d]: got %0d want %0d", i, got_g[i], exp_g[i]); end
    end
    bus.S_ARVALID = 2'b00;
    step();
  endtask

  task automatic test_backpressure();
    bit ok;
    apply_reset();
    bus.S_RREADY = 2'b01;
    drive_req(1, 32'h20);
    step();
    n_cmp++; if (GRANT !== 1'b1) begin n_bad++; $display("FAIL bp_grant: got %0d want 1", GRANT); end
    drop_req(1);
    wait_rvalid(1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL bp_timeout: got %b want 1", ok); end
    n_cmp++; if (bus.M_RREADY !== 1'b0) begin n_bad++; $display("FAIL bp_m_rready_low: got %b want 0", bus.M_RREADY); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.S_RVALID !== 2'b10) begin n_bad++; $display("FAIL bp_hold_rvalid[%0d]: got %b want 10", i, bus.S_RVALID); end
      n_cmp++; if (bus.S_RDATA !== 32'd50) begin n_bad++; $display("FAIL bp_hold_rdata[%0d]: got %0d want 50", i, bus.S_RDATA); end
      n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL bp_hold_busy[%0d]: got %b want 1", i, BUSY); end
    end
    @(negedge ACLK);
    bus.S_RREADY = 2'b11;
    #1;
    n_cmp++; if (bus.M_RREADY !== 1'b1) begin n_bad++; $display("FAIL bp_m_rready_high: got %b want 1", bus.M_RREADY); end
    step();
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL bp_done_busy: got %b want 0", BUSY); end
    n_cmp++; if (bus.S_RVALID !== 2'b00) begin n_bad++; $display("FAIL bp_done_rvalid: got %b want 00", bus.S_RVALID); end
  endtask

  task automatic test_reset_mid_data();
    bit ok;
    apply_reset();
    drive_req(1, 32'h20);
    step();
    drop_req(1);
    wait_rvalid(1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_pending_timeout: got %b want 1", ok); end
    @(negedge ACLK);
    ARSTn = 1'b0;
    #1;
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy: got %b want 0", BUSY); end
    n_cmp++; if (GRANT !== 1'b0) begin n_bad++; $display("FAIL rst_async_grant: got %0d want 0", GRANT); end
    n_cmp++; if (bus.S_RVALID !== 2'b00) begin n_bad++; $display("FAIL rst_async_rvalid: got %b want 00", bus.S_RVALID); end
    n_cmp++; if (bus.M_ARADDR !== 32'h0) begin n_bad++; $display("FAIL rst_async_araddr: got %h want 0", bus.M_ARADDR); end
    @(negedge ACLK);
    ARSTn        = 1'b1;
    bus.S_RREADY = 2'b11;
    drive_req(0, 32'h10);
    step();
    drop_req(0);
    wait_rvalid(0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL rst_after_timeout: got %b want 1", ok); end
    n_cmp++; if (bus.S_RDATA !== 32'd25) begin n_bad++; $display("FAIL rst_after_rdata: got %0d want 25", bus.S_RDATA); end
    step();
  endtask

  task automatic test_busy_ignored();
    bit ok;
    int pulses;
    apply_reset();
    bus.S_RREADY = 2'b11;
    drive_req(0, 32'h10);
    step();
    @(negedge ACLK);
    bus.S_ARVALID[0]    = 1'b0;
    bus.S_ARADDR[63:32] = 32'h20;
    bus.S_ARVALID[1]    = 1'b1;
    pulses = 0;
    ok     = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (bus.S_ARREADY[1]) pulses++;
      if (!BUSY) begin ok = 1'b1; break; end
    end
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL busy_idle_timeout: got %b want 1", ok); end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL busy_arready_leak: got %0d want 0", pulses); end
    step();
    n_cmp++; if (bus.S_ARREADY !== 2'b10) begin n_bad++; $display("FAIL busy_late_grant: got %b want 10", bus.S_ARREADY); end
    drop_req(1);
    wait_rvalid(1, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL busy_late_timeout: got %b want 1", ok); end
    n_cmp++; if (bus.S_RDATA !== 32'd50) begin n_bad++; $display("FAIL busy_late_rdata: got %0d want 50", bus.S_RDATA); end
    step();
  endtask

  task automatic test_unmapped();
    bit ok;
    apply_reset();
    bus.S_RREADY = 2'b11;
    drive_req(0, 32'h10);
    step();
    drop_req(0);
    wait_rvalid(0, ok);
    step();
    drive_req(0, 32'h30);
    step();
    drop_req(0);
    wait_rvalid(0, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL unmapped_timeout: got %b want 1", ok); end
    n_cmp++; if (bus.S_RDATA !== 32'd0) begin n_bad++; $display("FAIL unmapped_rdata: got %0d want 0", bus.S_RDATA); end
    n_cmp++; if (bus.S_RRESP !== 2'b00) begin n_bad++; $display("FAIL unmapped_rresp: got %b want 00", bus.S_RRESP); end
    step();
    n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL unmapped_idle: got %b want 0", BUSY); end
  endtask

  initial begin
    ARSTn         = 1'b0;
    bus.S_ARVALID = '0;
    bus.S_ARADDR  = '0;
    bus.S_RREADY  = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_reset_mid_data();
    test_busy_ignored();
    test_unmapped();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

endmodule
